i2c_writeframe: RTL and testbench

Single-byte I2C master transmitter, the write-side counterpart of the single-byte read frame engine. It optionally generates a START, shifts one byte out MSB-first on SDA, and samples the slave ACK on the 9th clock. It then either generates a STOP or keeps the bus (SCL low) so a following frame can continue the transaction. It runs on the 1 MHz system tick domain and drives the shared open-drain SDA/SCL pair.

---
 rtl/i2c_writeframe.sv | 183 ++++++++++++++++++
 tb/tb_i2c_writeframe.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/i2c_writeframe.sv
// Single-byte I2C master write frame: optional START, eight data bits MSB-first,
// slave ACK sample, then either STOP or a held bus (SCL low) for a chained frame.
module i2c_writeframe #(
    parameter int DELAY = 10
) (
    input  logic       clk_1MHz,
    input  logic       rst_n,
    input  logic       en_write,
    input  logic       start_frame,
    input  logic       stop_frame,
    input  logic [7:0] data_in,
    inout  wire        sda,
    output logic       scl,
    output logic       sda_en,
    output logic       done,
    output logic       ack,
    output logic       busy
);

    localparam int CW = (DELAY > 1) ? $clog2(DELAY) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DELAY - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(DELAY / 2);

    typedef enum logic [3:0] {
        IDLE,
        START_A,
        START_B,
        START_C,
        BIT_LOW,
        BIT_HIGH,
        ACK_LOW,
        ACK_HIGH,
        ACK_END,
        STOP_A,
        STOP_B,
        STOP_C,
        DONE
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          stop_q, stop_d;
    logic          ack_q, ack_d;
    logic          held_q, held_d;
    logic          scl_q, scl_d;
    logic          sda_en_q, sda_en_d;
    logic          sda_o_q, sda_o_d;
    logic          phase_end;

    always_ff @(posedge clk_1MHz or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            stop_q    <= 1'b0;
            ack_q     <= 1'b0;
            held_q    <= 1'b0;
            scl_q     <= 1'b1;
            sda_en_q  <= 1'b1;
            sda_o_q   <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            stop_q    <= stop_d;
            ack_q     <= ack_d;
            held_q    <= held_d;
            scl_q     <= scl_d;
            sda_en_q  <= sda_en_d;
            sda_o_q   <= sda_o_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        stop_d    = stop_q;
        ack_d     = ack_q;
        held_d    = held_q;
        phase_end = (cnt_q == CNT_LAST);

        if (state_q == IDLE || state_q == DONE) begin
            cnt_d = '0;
        end else begin
            cnt_d = phase_end ? '0 : cnt_q + CW'(1);
        end

        case (state_q)
            IDLE: begin
                if (en_write) begin
                    shift_d   = data_in;
                    stop_d    = stop_frame;
                    ack_d     = 1'b0;
                    bit_cnt_d = '0;
                    state_d   = start_frame ? START_A : BIT_LOW;
                end
            end
            START_A:  if (phase_end) state_d = START_B;
            START_B:  if (phase_end) state_d = START_C;
            START_C:  if (phase_end) state_d = BIT_LOW;
            BIT_LOW:  if (phase_end) state_d = BIT_HIGH;
            BIT_HIGH: begin
                if (phase_end) begin
                    if (bit_cnt_q == 3'd7) begin
                        state_d = ACK_LOW;
                    end else begin
                        shift_d   = {shift_q[6:0], 1'b0};
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        state_d   = BIT_LOW;
                    end
                end
            end
            ACK_LOW:  if (phase_end) state_d = ACK_HIGH;
            ACK_HIGH: begin
                // Sample mid-high so the slave has had half a phase to settle SDA.
                if (cnt_q == CNT_HALF) ack_d = ~sda;
                if (phase_end) state_d = ACK_END;
            end
            ACK_END: begin
                if (phase_end) begin
                    if (stop_q || !ack_q) begin
                        state_d = STOP_A;
                        held_d  = 1'b0;
                    end else begin
                        state_d = DONE;
                        held_d  = 1'b1;
                    end
                end
            end
            STOP_A:   if (phase_end) state_d = STOP_B;
            STOP_B:   if (phase_end) state_d = STOP_C;
            STOP_C:   if (phase_end) state_d = DONE;
            DONE:     state_d = IDLE;
            default:  state_d = IDLE;
        endcase

        // Bus pins are decoded from the next state so they switch with the state register.
        scl_d    = 1'b1;
        sda_en_d = 1'b1;
        sda_o_d  = 1'b1;
        case (state_d)
            IDLE, DONE: begin
                scl_d    = ~held_d;
                sda_en_d = ~held_d;
            end
            START_B: sda_o_d = 1'b0;
            START_C: begin
                scl_d   = 1'b0;
                sda_o_d = 1'b0;
            end
            BIT_LOW: begin
                scl_d   = 1'b0;
                sda_o_d = shift_d[7];
            end
            BIT_HIGH: sda_o_d = shift_d[7];
            ACK_LOW, ACK_END: begin
                scl_d    = 1'b0;
                sda_en_d = 1'b0;
            end
            ACK_HIGH: sda_en_d = 1'b0;
            STOP_A: begin
                scl_d   = 1'b0;
                sda_o_d = 1'b0;
            end
            STOP_B: sda_o_d = 1'b0;
            default: ;
        endcase
    end

    assign sda    = (sda_en_q && !sda_o_q) ? 1'b0 : 1'bz;
    assign scl    = scl_q;
    assign sda_en = sda_en_q;
    assign ack    = ack_q;
    assign done   = (state_q == DONE);
    assign busy   = (state_q != IDLE);

endmodule

// File: tb/tb_i2c_writeframe.sv
// Bench for i2c_writeframe: a bus monitor decodes START/bit/STOP events from SDA/SCL
// and compares them, the done latency and the idle bus state against a frame-level model.
module tb_i2c_writeframe;

    localparam int DELAY = 10;

    logic       clk_1MHz = 1'b0;
    logic       rst_n;
    logic       en_write;
    logic       start_frame;
    logic       stop_frame;
    logic [7:0] data_in;
    wire        sda;
    logic       scl;
    logic       sda_en;
    logic       done;
    logic       ack;
    logic       busy;
    logic       slave_ack_en;

    int errors = 0;
    int checks = 0;
    bit held_m = 1'b0;

    // Event codes: 0/1 data bit, 2 START, 3 STOP
    logic [1:0] ev_q[$];
    logic [1:0] exp_q[$];
    logic       prev_scl = 1'b1;
    logic       prev_sda = 1'b1;
    bit         cond_seen = 1'b0;

    always #5 clk_1MHz = ~clk_1MHz;

    i2c_writeframe #(.DELAY(DELAY)) dut (
        .clk_1MHz   (clk_1MHz),
        .rst_n      (rst_n),
        .en_write   (en_write),
        .start_frame(start_frame),
        .stop_frame (stop_frame),
        .data_in    (data_in),
        .sda        (sda),
        .scl        (scl),
        .sda_en     (sda_en),
        .done       (done),
        .ack        (ack),
        .busy       (busy)
    );

    // The slave pulls SDA low whenever the master releases it inside a frame.
    assign sda = (slave_ack_en && busy && !sda_en) ? 1'b0 : 1'bz;
    pullup (sda);

    // Bus monitor: a bit is the SDA level held across one SCL high period with no START/STOP in it.
    always @(negedge clk_1MHz) begin
        if (prev_scl && scl && prev_sda && !sda) begin
            ev_q.push_back(2'd2);
            cond_seen = 1'b1;
        end else if (prev_scl && scl && !prev_sda && sda) begin
            ev_q.push_back(2'd3);
            cond_seen = 1'b1;
        end
        if (prev_scl && !scl) begin
            if (!cond_seen) ev_q.push_back({1'b0, prev_sda});
            cond_seen = 1'b0;
        end
        if (!prev_scl && scl) cond_seen = 1'b0;
        prev_scl = scl;
        prev_sda = sda;
    end

    function automatic logic [31:0] packEvents(input logic [1:0] q[$]);
        logic [31:0] v;
        v = '0;
        foreach (q[i]) v = (v << 2) | {30'd0, q[i]};
        v[31:24] = 8'(q.size());
        return v;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] d, input bit st, input bit sp, input bit sack,
                                 input bit hold_en);
        int edges;
        @(negedge clk_1MHz);
        #1;
        data_in      = d;
        start_frame  = st;
        stop_frame   = sp;
        slave_ack_en = sack;
        en_write     = 1'b1;
        ev_q.delete();
        edges = 0;
        do begin
            @(posedge clk_1MHz);
            #1;
            edges++;
        end while (!busy && edges < 8);
        checkOutput("request_edge", 32'(edges), 32'd1);
        if (!hold_en) en_write = 1'b0;
        data_in     = 8'($urandom);
        start_frame = 1'($urandom);
        stop_frame  = 1'($urandom);
    endtask

    task automatic checkFrame(input logic [7:0] d, input bit st, input bit sp, input bit sack);
        int n;
        int len;
        bit stop_eff;
        stop_eff = sp || !sack;
        len = DELAY * (16 + 3 + (st ? 3 : 0) + (stop_eff ? 3 : 0));
        n = 0;
        do begin
            @(posedge clk_1MHz);
            #1;
            n++;
        end while (!done && n < 400);
        checkOutput("done_latency", 32'(n), 32'(len));
        checkOutput("ack_at_done", 32'(ack), 32'(sack));
        exp_q.delete();
        if (st) exp_q.push_back(2'd2);
        for (int i = 7; i >= 0; i--) exp_q.push_back({1'b0, d[i]});
        exp_q.push_back({1'b0, !sack});
        if (stop_eff) exp_q.push_back(2'd3);
        checkOutput("bus_events", packEvents(ev_q), packEvents(exp_q));
        held_m = !stop_eff;
        @(posedge clk_1MHz);
        #1;
        checkOutput("idle_busy", 32'(busy), 32'd0);
        checkOutput("idle_done", 32'(done), 32'd0);
        checkOutput("idle_scl", 32'(scl), 32'(!held_m));
        checkOutput("idle_sda_en", 32'(sda_en), 32'(!held_m));
        checkOutput("ack_hold", 32'(ack), 32'(sack));
    endtask

    task automatic runFrame(input logic [7:0] d, input bit st, input bit sp, input bit sack);
        applyStimulus(d, st, sp, sack, 1'b0);
        checkFrame(d, st, sp, sack);
    endtask

    initial begin
        logic [7:0] d;
        bit st, sp, sack;

        rst_n        = 1'b0;
        en_write     = 1'b0;
        start_frame  = 1'b0;
        stop_frame   = 1'b0;
        data_in      = 8'h00;
        slave_ack_en = 1'b0;
        repeat (3) @(posedge clk_1MHz);
        #1;
        checkOutput("rst_scl", 32'(scl), 32'd1);
        checkOutput("rst_sda_en", 32'(sda_en), 32'd1);
        checkOutput("rst_sda", 32'(sda), 32'd1);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_ack", 32'(ack), 32'd0);
        @(negedge clk_1MHz);
        rst_n = 1'b1;

        runFrame(8'hA5, 1'b1, 1'b1, 1'b1);
        runFrame(8'h00, 1'b1, 1'b0, 1'b0);

        runFrame(8'h3C, 1'b1, 1'b0, 1'b1);
        runFrame(8'h96, 1'b0, 1'b0, 1'b1);
        runFrame(8'hFF, 1'b0, 1'b1, 1'b1);

        runFrame(8'h81, 1'b1, 1'b0, 1'b1);
        runFrame(8'h42, 1'b1, 1'b1, 1'b1);

        // Abort during the high phase of the fourth data bit
        applyStimulus(8'hC3, 1'b1, 1'b1, 1'b1, 1'b0);
        repeat (104) @(posedge clk_1MHz);
        #1;
        checkOutput("pre_reset_scl", 32'(scl), 32'd1);
        checkOutput("pre_reset_busy", 32'(busy), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("abort_scl", 32'(scl), 32'd1);
        checkOutput("abort_sda_en", 32'(sda_en), 32'd1);
        checkOutput("abort_sda", 32'(sda), 32'd1);
        checkOutput("abort_busy", 32'(busy), 32'd0);
        checkOutput("abort_done", 32'(done), 32'd0);
        checkOutput("abort_ack", 32'(ack), 32'd0);
        @(negedge clk_1MHz);
        rst_n  = 1'b1;
        held_m = 1'b0;
        runFrame(8'hC3, 1'b1, 1'b1, 1'b1);

        // en_write held high across three frames; data_in is scrambled after each request
        for (int k = 0; k < 3; k++) begin
            d    = 8'($urandom);
            sack = ($urandom_range(0, 3) != 0);
            applyStimulus(d, 1'b1, 1'b1, sack, (k < 2));
            checkFrame(d, 1'b1, 1'b1, sack);
        end

        for (int k = 0; k < 6; k++) begin
            d    = 8'($urandom);
            st   = held_m ? 1'($urandom) : 1'b1;
            sp   = 1'($urandom);
            sack = ($urandom_range(0, 3) != 0);
            runFrame(d, st, sp, sack);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
